// File: rtl/display_mux_sseg.sv
// Time-multiplexed seven-segment driver: scans NDIG hex digits from a shadow register.
// Optional build macro LZ_BLANK_EN darkens leading-zero digits above the most significant non-zero nibble.
module display_mux_sseg #(
    parameter int NDIG        = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4*NDIG-1:0]   data,
    input  logic                load,
    input  logic [NDIG-1:0]     blank,
    output logic [0:6]          SSeg,
    output logic [NDIG-1:0]     an,
    output logic                scan_tick
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [4*NDIG-1:0] shadow_q, shadow_d;
    logic              tick_q, tick_d;
    logic [0:6]        sseg_q, sseg_d;
    logic [NDIG-1:0]   an_q, an_d;
    logic              advance_s;
    logic [3:0]        nibble_s;
    logic              dark_s;
    logic [NDIG-1:0]   lz_mask_s;

    // Hex nibble to active-low abcdefg pattern.
    function automatic logic [0:6] seg_enc(input logic [3:0] nib);
        logic [0:6] seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            4'hF:    seg = 7'b0111000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // Refresh divider, digit index, shadow capture and scan tick next-state.
    always_comb begin
        advance_s = (cnt_q == CNT_LAST);
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        if (advance_s) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        if (load) begin
            shadow_d = data;
        end else begin
            shadow_d = shadow_q;
        end
        tick_d = advance_s;
    end

`ifdef LZ_BLANK_EN
    logic lz_seen_s;

    // A digit is dark when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        lz_mask_s = '0;
        lz_seen_s = 1'b0;
        for (int k = NDIG - 1; k >= 1; k--) begin
            if (shadow_q[4*k +: 4] != 4'h0) begin
                lz_seen_s = 1'b1;
            end else begin
                lz_seen_s = lz_seen_s;
            end
            lz_mask_s[k] = ~lz_seen_s;
        end
    end
`else
    // Leading-zero suppression not built: no extra masking.
    always_comb begin
        lz_mask_s = '0;
    end
`endif

    // Output decode from the registered index and shadow, so outputs lag state by one edge.
    always_comb begin
        nibble_s = shadow_q[4*idx_q +: 4];
        dark_s   = blank[idx_q] | lz_mask_s[idx_q];
        an_d     = {NDIG{1'b1}};
        sseg_d   = 7'b1111111;
        if (!dark_s) begin
            an_d[idx_q] = 1'b0;
            sseg_d      = seg_enc(nibble_s);
        end else begin
            an_d   = {NDIG{1'b1}};
            sseg_d = 7'b1111111;
        end
    end

    // State and output registers; reset leaves the display fully dark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            tick_q   <= 1'b0;
            sseg_q   <= 7'b1111111;
            an_q     <= {NDIG{1'b1}};
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            tick_q   <= tick_d;
            sseg_q   <= sseg_d;
            an_q     <= an_d;
        end
    end

    assign SSeg      = sseg_q;
    assign an        = an_q;
    assign scan_tick = tick_q;

endmodule

// File: tb/tb_display_mux_sseg.sv
// Directed self-checking bench for display_mux_sseg with NDIG=4, REFRESH_DIV=4.
module tb_display_mux_sseg;

    logic        clk;
    logic        rst_n;
    logic [15:0] data;
    logic        load;
    logic [3:0]  blank;
    logic [0:6]  SSeg;
    logic [3:0]  an;
    logic        scan_tick;

    int checks;
    int failures;

    logic [3:0] an_tab  [4];
    logic [0:6] seg_12af[4];

    display_mux_sseg #(.NDIG(4), .REFRESH_DIV(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data      (data),
        .load      (load),
        .blank     (blank),
        .SSeg      (SSeg),
        .an        (an),
        .scan_tick (scan_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0;
        load  = 1'b0;
        data  = 16'h0000;
        blank = 4'b0000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        data = 16'h12AF;
        load = 1'b1;
        @(negedge clk);
        checks++;
        if (an !== 4'b1111) begin $display("FAIL reset_an got=%b exp=1111", an); failures++; end
        checks++;
        if (SSeg !== 7'b1111111) begin $display("FAIL reset_sseg got=%b exp=1111111", SSeg); failures++; end
        checks++;
        if (scan_tick !== 1'b0) begin $display("FAIL reset_tick got=%b exp=0", scan_tick); failures++; end
        load  = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (an !== 4'b1110) begin $display("FAIL release_an got=%b exp=1110", an); failures++; end
        checks++;
        if (SSeg !== 7'b0000001) begin $display("FAIL release_sseg got=%b exp=0000001", SSeg); failures++; end
        @(negedge clk);
        checks++;
        if (SSeg !== 7'b0000001) begin $display("FAIL load_in_reset got=%b exp=0000001", SSeg); failures++; end
    endtask

    task automatic test_scan();
        logic [3:0] exp_an;
        logic       exp_tick;
        do_reset();
        rst_n = 1'b1;
        for (int cyc = 1; cyc <= 17; cyc++) begin
            @(negedge clk);
            exp_an   = an_tab[((cyc - 1) / 4) % 4];
            exp_tick = ((cyc % 4) == 0);
            checks++;
            if (an !== exp_an) begin $display("FAIL scan_an cyc=%0d got=%b exp=%b", cyc, an, exp_an); failures++; end
            checks++;
            if (scan_tick !== exp_tick) begin $display("FAIL scan_tick cyc=%0d got=%b exp=%b", cyc, scan_tick, exp_tick); failures++; end
        end
    endtask

    task automatic test_load();
        int d;
        do_reset();
        data  = 16'h12AF;
        load  = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        load = 1'b0;
        data = 16'h3333;
        for (int cyc = 2; cyc <= 18; cyc++) begin
            @(negedge clk);
            d = ((cyc - 1) / 4) % 4;
            checks++;
            if (SSeg !== seg_12af[d] || an !== an_tab[d]) begin
                $display("FAIL load_digit cyc=%0d got=%b/%b exp=%b/%b", cyc, SSeg, an, seg_12af[d], an_tab[d]);
                failures++;
            end
        end
    endtask

    task automatic test_blank();
        int d;
        do_reset();
        data  = 16'h12AF;
        load  = 1'b1;
        blank = 4'b0100;
        rst_n = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int cyc = 2; cyc <= 17; cyc++) begin
            @(negedge clk);
            d = ((cyc - 1) / 4) % 4;
            checks++;
            if (d == 2) begin
                if (SSeg !== 7'b1111111 || an !== 4'b1111) begin
                    $display("FAIL blank_dark cyc=%0d got=%b/%b exp=1111111/1111", cyc, SSeg, an);
                    failures++;
                end
            end else begin
                if (SSeg !== seg_12af[d] || an !== an_tab[d]) begin
                    $display("FAIL blank_other cyc=%0d got=%b/%b exp=%b/%b", cyc, SSeg, an, seg_12af[d], an_tab[d]);
                    failures++;
                end
            end
        end
        blank = 4'b0000;
    endtask

    task automatic test_lz();
        int         d;
        logic [0:6] exp_seg;
        logic [3:0] exp_an;
        do_reset();
        data  = 16'h0005;
        load  = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int cyc = 2; cyc <= 17; cyc++) begin
            @(negedge clk);
            d = ((cyc - 1) / 4) % 4;
            if (d == 0) begin
                exp_seg = 7'b0100100;
                exp_an  = 4'b1110;
            end else begin
`ifdef LZ_BLANK_EN
                exp_seg = 7'b1111111;
                exp_an  = 4'b1111;
`else
                exp_seg = 7'b0000001;
                exp_an  = an_tab[d];
`endif
            end
            checks++;
            if (SSeg !== exp_seg || an !== exp_an) begin
                $display("FAIL lz_digit cyc=%0d got=%b/%b exp=%b/%b", cyc, SSeg, an, exp_seg, exp_an);
                failures++;
            end
        end
    endtask

    task automatic test_load_on_advance();
        do_reset();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        data = 16'h12AF;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (SSeg !== 7'b0000001 || an !== 4'b1110) begin
            $display("FAIL adv_load_before got=%b/%b exp=0000001/1110", SSeg, an);
            failures++;
        end
        @(negedge clk);
        checks++;
        if (SSeg !== 7'b0001000 || an !== 4'b1101) begin
            $display("FAIL adv_load_after got=%b/%b exp=0001000/1101", SSeg, an);
            failures++;
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        data  = 16'h12AF;
        load  = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if (SSeg !== 7'b0010010 || an !== 4'b1011) begin
            $display("FAIL mid_pre got=%b/%b exp=0010010/1011", SSeg, an);
            failures++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (an !== 4'b1111 || SSeg !== 7'b1111111 || scan_tick !== 1'b0) begin
            $display("FAIL mid_async got=%b/%b/%b exp=1111/1111111/0", an, SSeg, scan_tick);
            failures++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            if (cyc == 1 || cyc == 6) begin
                checks++;
                if (SSeg !== 7'b0000001 || an !== an_tab[(cyc - 1) / 4]) begin
                    $display("FAIL mid_restart cyc=%0d got=%b/%b exp=0000001/%b", cyc, SSeg, an, an_tab[(cyc - 1) / 4]);
                    failures++;
                end
            end
            if (cyc == 4) begin
                checks++;
                if (scan_tick !== 1'b1) begin $display("FAIL mid_tick got=%b exp=1", scan_tick); failures++; end
            end
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        an_tab[0]   = 4'b1110;
        an_tab[1]   = 4'b1101;
        an_tab[2]   = 4'b1011;
        an_tab[3]   = 4'b0111;
        seg_12af[0] = 7'b0111000;
        seg_12af[1] = 7'b0001000;
        seg_12af[2] = 7'b0010010;
        seg_12af[3] = 7'b1001111;
        rst_n = 1'b0;
        load  = 1'b0;
        data  = 16'h0000;
        blank = 4'b0000;
        test_reset();
        test_scan();
        test_load();
        test_blank();
        test_lz();
        test_load_on_advance();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_mux_sseg.md
DISPLAY_MUX_SSEG -- requirements
Module: display_mux_sseg

Interface
REQ-001 SHALL have parameter NDIG, default 4, number of multiplexed digits (1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, clk cycles each digit is held (>=2).
REQ-003 SHALL have port clk  input  1  single system clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port data  input  4*NDIG  hex nibbles; digit k = data[4k+3:4k], digit 0 rightmost.
REQ-006 SHALL have port load  input  1  strobe; captures data into shadow register.
REQ-007 SHALL have port blank  input  NDIG  per-digit blank mask, 1 = digit dark.
REQ-008 SHALL have port SSeg  output  7  registered segments [0:6] = abcdefg, active-low.
REQ-009 SHALL have port an  output  NDIG  registered anode enables, active-low, at most one low.
REQ-010 SHALL have port scan_tick  output  1  one-cycle pulse on each digit advance.

Function
REQ-011 SHALL keep a refresh counter counting 0..REFRESH_DIV-1, wrapping to 0 and asserting an internal advance on the count REFRESH_DIV-1.
REQ-012 SHALL keep a digit index 0..NDIG-1 incremented on advance, NDIG-1 wrapping to 0.
REQ-013 SHALL register scan_tick high for exactly the cycle after the advance edge.
REQ-014 SHALL capture data into the shadow register on any clk edge with load=1; display SHALL use only the shadow register, never data directly.
REQ-015 SHALL compute SSeg and an every cycle from current index, shadow and blank, registered: new shadow value visible on SSeg one edge after capture.
REQ-016 SHALL drive an = all ones except bit [index] low, unless digit [index] is blanked, in which case an = all ones and SSeg = 7'b1111111.
REQ-017 SHALL encode nibbles 0-F as: 0000001,1001111,0010010,0000110,1001100,0100100,0100000,0001111,0000000,0000100,0001000,1100000,0110001,1000010,0110000,0111000.
REQ-018 SHALL, on load coinciding with advance, capture the shadow and advance the index on the same edge; the following output edge SHALL show new data at new index.
REQ-019 SHALL change blank combinationally into the output register (effective one edge later), with no effect on counters.
REQ-020 SHALL ignore load while rst_n=0.

Reset
REQ-021 SHALL, while rst_n=0, force refresh counter=0, index=0, shadow=0, scan_tick=0, an=all ones, SSeg=7'b1111111, independent of clk.
REQ-022 SHALL, on the first edge after rst_n rises, drive an with bit 0 low and SSeg=7'b0000001 (unless blank[0]=1).
REQ-023 SHALL, on reset asserted mid-scan, abandon the current digit with no partial state retained.

Configuration
REQ-024 SHALL provide macro LZ_BLANK_EN; when defined, digits above the most significant non-zero shadow nibble SHALL be blanked as in REQ-016 (digit 0 never suppressed, combined by OR with blank).
REQ-025 SHALL, without LZ_BLANK_EN, display every non-masked digit including leading zeros; ports identical in both builds.

Verification (NDIG=4, REFRESH_DIV=4)
REQ-026 SHALL check reset release: an 1111 -> next edge 1110, SSeg 0000001; scan_tick every 4 cycles; an sequence 1110,1101,1011,0111,1110.
REQ-027 SHALL check load data=16'h12AF: digit0 SSeg 0111000 (F), digit1 0001000 (A), digit2 0010010, digit3 1001111; data changed without load -> SSeg unchanged.
REQ-028 SHALL check blank=4'b0100: during index 2 an=1111, SSeg=1111111; other digits unaffected.
REQ-029 SHALL check load data=16'h0005 with LZ_BLANK_EN: digits 3..1 dark, digit 0 shows 0100100; without macro digits 3..1 show 0000001.
REQ-030 SHALL check load pulsed on the advance edge: next output edge shows new nibble at new index; rst_n pulsed low mid-digit 2 -> an=1111 immediately, restart at digit 0 with shadow 0.
